// File: rtl/lsu_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_ctrl_if
//   Bundles the pipeline request/response handshake and the data memory port
//   of the load/store controller.
//   slave  : the view of lsu_ctrl itself (accepts requests, drives memory).
//   master : the view of the surrounding pipeline + memory.
//   Signals:
//     req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  request
//     rsp_valid/rsp_rdata/rsp_err                               response
//     mem_addr/mem_we/mem_wdata/mem_whb/mem_rdata               memory port
// ----------------------------------------------------------------------------
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_whb;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_we, mem_wdata, mem_whb
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_we, mem_wdata, mem_whb
    );
endinterface

// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
//   Core-side load/store initiator. Accepts one request at a time, maps RISC-V
//   funct3 onto memory whb codes, splits misaligned word accesses into two
//   halfword accesses (or flags them as errors when SPLIT_MISALIGNED=0) and
//   returns one registered response pulse per request.
//   Ports:
//     clk  : clock, all state on posedge
//     rst  : synchronous active-high reset
//     bus  : lsu_ctrl_if.slave (request, response and memory port)
//   Memory whb codes: 000 B, 001 H, 010 W, 011 BU, 100 HU.
// ----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        ERR  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Illegal funct3: loads 011/110/111, stores anything but B/H/W.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = we;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // funct3 -> memory whb code.
    function automatic logic [2:0] whb_map(input logic [2:0] f3);
        logic [2:0] code;
        case (f3)
            3'b000:  code = 3'b000;
            3'b001:  code = 3'b001;
            3'b010:  code = 3'b010;
            3'b100:  code = 3'b011;
            3'b101:  code = 3'b100;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    state_t      state_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [15:0] wdata_hi_r;   // upper store half, needed only for the HI access
    logic [15:0] lo_r;         // low half captured during LO
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic [31:0] mem_addr_r;
    logic        mem_we_r;
    logic [31:0] mem_wdata_r;
    logic [2:0]  mem_whb_r;

    logic        illegal_s;
    logic        mis_word_s;
    logic [2:0]  whb_s;

    // Decode of the request currently offered on the bus.
    always_comb begin
        illegal_s  = f3_illegal(bus.req_we, bus.req_funct3);
        mis_word_s = (bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00);
        whb_s      = whb_map(bus.req_funct3);
    end

    // Request/response FSM; all bus outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_hi_r  <= 16'h0000;
            lo_r        <= 16'h0000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
            mem_whb_r   <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_r        <= bus.req_we;
                        addr_r      <= bus.req_addr;
                        wdata_hi_r  <= bus.req_wdata[31:16];
                        req_ready_r <= 1'b0;
                        if (illegal_s || (mis_word_s && !SPLIT_MISALIGNED)) begin
                            // Error response is visible in the very next cycle.
                            state_r     <= ERR;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else if (mis_word_s) begin
                            state_r     <= LO;
                            mem_addr_r  <= bus.req_addr;
                            mem_we_r    <= bus.req_we;
                            mem_whb_r   <= bus.req_we ? 3'b001 : 3'b100;
                            mem_wdata_r <= bus.req_we ? {16'h0000, bus.req_wdata[15:0]}
                                                      : 32'h0000_0000;
                        end else begin
                            state_r     <= ACC;
                            mem_addr_r  <= bus.req_addr;
                            mem_we_r    <= bus.req_we;
                            mem_whb_r   <= whb_s;
                            mem_wdata_r <= bus.req_we ? bus.req_wdata : 32'h0000_0000;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC: begin
                    state_r     <= DONE;
                    mem_addr_r  <= 32'h0000_0000;
                    mem_we_r    <= 1'b0;
                    mem_wdata_r <= 32'h0000_0000;
                    mem_whb_r   <= 3'b000;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= we_r ? 32'h0000_0000 : bus.mem_rdata;
                end
                LO: begin
                    // Second half keeps the same whb and write enable.
                    state_r     <= HI;
                    lo_r        <= bus.mem_rdata[15:0];
                    mem_addr_r  <= addr_r + 32'd2;
                    mem_wdata_r <= we_r ? {16'h0000, wdata_hi_r} : 32'h0000_0000;
                end
                HI: begin
                    state_r     <= DONE;
                    mem_addr_r  <= 32'h0000_0000;
                    mem_we_r    <= 1'b0;
                    mem_wdata_r <= 32'h0000_0000;
                    mem_whb_r   <= 3'b000;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= we_r ? 32'h0000_0000 : {bus.mem_rdata[15:0], lo_r};
                end
                ERR, DONE: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    mem_addr_r  <= 32'h0000_0000;
                    mem_we_r    <= 1'b0;
                    mem_wdata_r <= 32'h0000_0000;
                    mem_whb_r   <= 3'b000;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_whb   = mem_whb_r;
    // The write commits on the edge that ends the access cycle; if reset hits
    // that same edge the access is aborted, so it must not write either.
    assign bus.mem_we    = mem_we_r & ~rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Two controllers (SPLIT_MISALIGNED=1 and =0), each with a byte-addressed
//   memory model (256 bytes, address taken modulo 256). Directed vector table,
//   a reset-in-HI sequence and randomized requests checked against a
//   reference model working on whole-request semantics.
// ----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if b1();
    lsu_ctrl_if b0();

    lsu_ctrl #(.SPLIT_MISALIGNED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    lsu_ctrl #(.SPLIT_MISALIGNED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    int total = 0;
    int bad   = 0;

    logic [2047:0] sim_mem1 = '0;
    logic [2047:0] sim_mem0 = '0;
    logic [2047:0] ref_mem1 = '0;
    logic [2047:0] ref_mem0 = '0;

    function automatic logic [7:0] getb(input logic [2047:0] m, input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        return m[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [2047:0] put(input logic [2047:0] m, input logic [31:0] a,
                                          input int n, input logic [31:0] d);
        logic [2047:0] r;
        logic [7:0]    idx;
        r = m;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                idx = a[7:0] + 8'(i);
                r[{idx, 3'b000} +: 8] = d[8*i +: 8];
            end
        end
        return r;
    endfunction

    function automatic int whb_bytes(input logic [2:0] whb);
        case (whb)
            3'b000, 3'b011: return 1;
            3'b001, 3'b100: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Memory side: combinational read with extension selected by whb.
    function automatic logic [31:0] mem_read(input logic [2047:0] m, input logic [31:0] a,
                                             input logic [2:0] whb);
        logic [7:0] x0, x1, x2, x3;
        x0 = getb(m, a);
        x1 = getb(m, a + 32'd1);
        x2 = getb(m, a + 32'd2);
        x3 = getb(m, a + 32'd3);
        case (whb)
            3'b000:  return {{24{x0[7]}}, x0};
            3'b001:  return {{16{x1[7]}}, x1, x0};
            3'b010:  return {x3, x2, x1, x0};
            3'b011:  return {24'h0, x0};
            3'b100:  return {16'h0, x1, x0};
            default: return 32'h0;
        endcase
    endfunction

    assign b1.mem_rdata = mem_read(sim_mem1, b1.mem_addr, b1.mem_whb);
    assign b0.mem_rdata = mem_read(sim_mem0, b0.mem_addr, b0.mem_whb);

    always @(posedge clk) begin
        if (b1.mem_we) sim_mem1 <= put(sim_mem1, b1.mem_addr, whb_bytes(b1.mem_whb), b1.mem_wdata);
        if (b0.mem_we) sim_mem0 <= put(sim_mem0, b0.mem_addr, whb_bytes(b0.mem_whb), b0.mem_wdata);
    end

    // ---------------- reference model (request level) ----------------
    function automatic logic ref_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 <= 3'd2);
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2047:0] m, input logic [31:0] a,
                                             input logic [2:0] f3);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < ref_size(f3); i++) v = v | (32'(getb(m, a + 32'(i))) << (8*i));
        case (f3)
            3'd0:    return (v[7]  ? 32'hFFFF_FF00 : 32'h0) | v;
            3'd1:    return (v[15] ? 32'hFFFF_0000 : 32'h0) | v;
            default: return v;
        endcase
    endfunction

    function automatic logic [2:0] ref_whb(input logic we, input logic [2:0] f3, input logic split);
        if (split) return we ? 3'd1 : 3'd4;
        case (f3)
            3'd4:    return 3'd3;
            3'd5:    return 3'd4;
            default: return f3;
        endcase
    endfunction

    // ---------------- DUT selection / sampling ----------------
    int sel = 1;
    logic        s_ready, s_rv, s_err, s_we;
    logic [31:0] s_rd, s_addr, s_wdata;
    logic [2:0]  s_whb;
    assign s_ready = (sel == 1) ? b1.req_ready : b0.req_ready;
    assign s_rv    = (sel == 1) ? b1.rsp_valid : b0.rsp_valid;
    assign s_err   = (sel == 1) ? b1.rsp_err   : b0.rsp_err;
    assign s_rd    = (sel == 1) ? b1.rsp_rdata : b0.rsp_rdata;
    assign s_we    = (sel == 1) ? b1.mem_we    : b0.mem_we;
    assign s_addr  = (sel == 1) ? b1.mem_addr  : b0.mem_addr;
    assign s_wdata = (sel == 1) ? b1.mem_wdata : b0.mem_wdata;
    assign s_whb   = (sel == 1) ? b1.mem_whb   : b0.mem_whb;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (dut%0d, t=%0t): got=0x%08h want=0x%08h", nm, sel, $time, got, exp);
        end
    endtask

    task automatic chk_img(input int w);
        logic [2047:0] s, r;
        s = (w == 1) ? sim_mem1 : sim_mem0;
        r = (w == 1) ? ref_mem1 : ref_mem0;
        total++;
        if (s !== r) begin
            bad++;
            for (int i = 0; i < 256; i++) begin
                if (s[8*i +: 8] !== r[8*i +: 8]) begin
                    $display("FAIL mem_image (dut%0d): byte 0x%02h got=0x%02h want=0x%02h",
                             w, i, s[8*i +: 8], r[8*i +: 8]);
                    break;
                end
            end
        end
    endtask

    task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        if (sel == 1) begin
            b1.req_valid = v; b1.req_we = we; b1.req_funct3 = f3; b1.req_addr = a; b1.req_wdata = d;
        end else begin
            b0.req_valid = v; b0.req_we = we; b0.req_funct3 = f3; b0.req_addr = a; b0.req_wdata = d;
        end
    endtask

    // One request; returns the response and what was seen on the memory port.
    task automatic do_txn(input int w, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int wec, output logic [2:0] whb0, output logic [31:0] addr1);
        sel = w;
        @(negedge clk);
        chk("ready_idle", {31'h0, s_ready}, 32'd1);
        set_req(1'b1, we, f3, a, d);
        @(negedge clk);
        set_req(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
        lat = 0; err = 1'b0; rd = 32'h0; wec = 0; whb0 = 3'd0; addr1 = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            chk("ready_busy", {31'h0, s_ready}, 32'd0);
            if (s_rv) begin
                lat = k; err = s_err; rd = s_rd;
                chk("mem_addr_idle", s_addr, 32'h0);
                chk("mem_wdata_idle", s_wdata, 32'h0);
                chk("mem_ctl_idle", {28'h0, s_we, s_whb}, 32'h0);
                break;
            end
            if (s_we) wec++;
            if (k == 1) whb0 = s_whb;
            if (k == 2) addr1 = s_addr;
        end
    endtask

    task automatic run_check(input int w, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input int e_lat, input logic e_err, input logic [31:0] e_rd,
                             input int e_wec, input logic [2:0] e_whb, input logic [31:0] e_addr1);
        int lat, wec;
        logic err;
        logic [31:0] rd, addr1;
        logic [2:0] whb0;
        do_txn(w, we, f3, a, d, lat, err, rd, wec, whb0, addr1);
        chk("rsp_latency", 32'(lat), 32'(e_lat));
        chk("rsp_err", {31'h0, err}, {31'h0, e_err});
        chk("rsp_rdata", rd, e_rd);
        chk("mem_we_cycles", 32'(wec), 32'(e_wec));
        if (e_lat > 1) chk("mem_whb", {29'h0, whb0}, {29'h0, e_whb});
        if (e_lat == 3) chk("split_addr2", addr1, e_addr1);
        if (we && !e_err) begin
            if (w == 1) ref_mem1 = put(ref_mem1, a, ref_size(f3), d);
            else        ref_mem0 = put(ref_mem0, a, ref_size(f3), d);
        end
        chk_img(w);
    endtask

    typedef struct {
        int          w;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          wec;
        logic [2:0]  whb;
        logic [31:0] addr1;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int          nrv, w, e_lat, e_wec;
        logic        we, e_err, mis, split;
        logic [2:0]  f3;
        logic [31:0] a, d, e_rd;

        //        w  we  f3      addr          wdata         lat err rdata         wec whb     addr1
        tbl[0]  = '{1, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0000, 1, 3'd2, 32'h0};
        tbl[1]  = '{1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 0, 3'd2, 32'h0};
        tbl[2]  = '{1, 1'b1, 3'd2, 32'h0000_0010, 32'h0000_80FF, 2, 1'b0, 32'h0000_0000, 1, 3'd2, 32'h0};
        tbl[3]  = '{1, 1'b0, 3'd0, 32'h0000_0011, 32'h0,         2, 1'b0, 32'hFFFF_FF80, 0, 3'd0, 32'h0};
        tbl[4]  = '{1, 1'b0, 3'd4, 32'h0000_0011, 32'h0,         2, 1'b0, 32'h0000_0080, 0, 3'd3, 32'h0};
        tbl[5]  = '{1, 1'b1, 3'd2, 32'h0000_0013, 32'h1122_3344, 3, 1'b0, 32'h0000_0000, 2, 3'd1, 32'h0000_0015};
        tbl[6]  = '{1, 1'b0, 3'd2, 32'h0000_0013, 32'h0,         3, 1'b0, 32'h1122_3344, 0, 3'd4, 32'h0000_0015};
        tbl[7]  = '{1, 1'b0, 3'd1, 32'h0000_0013, 32'h0,         2, 1'b0, 32'h0000_3344, 0, 3'd1, 32'h0};
        tbl[8]  = '{1, 1'b0, 3'd3, 32'h0000_0010, 32'h0,         1, 1'b1, 32'h0000_0000, 0, 3'd0, 32'h0};
        tbl[9]  = '{1, 1'b1, 3'd4, 32'h0000_0010, 32'h5555_5555, 1, 1'b1, 32'h0000_0000, 0, 3'd0, 32'h0};
        tbl[10] = '{1, 1'b0, 3'd5, 32'h0000_0012, 32'h0,         2, 1'b0, 32'h0000_4400, 0, 3'd4, 32'h0};
        tbl[11] = '{1, 1'b0, 3'd0, 32'h0000_0016, 32'h0,         2, 1'b0, 32'h0000_0011, 0, 3'd0, 32'h0};
        tbl[12] = '{0, 1'b0, 3'd2, 32'h0000_0022, 32'h0,         1, 1'b1, 32'h0000_0000, 0, 3'd0, 32'h0};
        tbl[13] = '{0, 1'b1, 3'd2, 32'h0000_0023, 32'h1234_5678, 1, 1'b1, 32'h0000_0000, 0, 3'd0, 32'h0};
        tbl[14] = '{0, 1'b1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_0000, 1, 3'd2, 32'h0};
        tbl[15] = '{0, 1'b0, 3'd2, 32'h0000_0020, 32'h0,         2, 1'b0, 32'hCAFE_F00D, 0, 3'd2, 32'h0};
        tbl[16] = '{0, 1'b0, 3'd3, 32'h0000_0020, 32'h0,         1, 1'b1, 32'h0000_0000, 0, 3'd0, 32'h0};
        tbl[17] = '{0, 1'b0, 3'd1, 32'h0000_0021, 32'h0,         2, 1'b0, 32'hFFFF_FEF0, 0, 3'd1, 32'h0};
        tbl[18] = '{1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hAABB_CCDD, 3, 1'b0, 32'h0000_0000, 2, 3'd1, 32'h0000_0001};
        tbl[19] = '{1, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0,         3, 1'b0, 32'hAABB_CCDD, 0, 3'd4, 32'h0000_0001};

        rst = 1'b1;
        sel = 1; set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        sel = 0; set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk("rst_rsp_valid", {31'h0, s_rv}, 32'd0);
            chk("rst_rsp_rdata", s_rd, 32'h0);
            chk("rst_rsp_err", {31'h0, s_err}, 32'd0);
            chk("rst_mem_we", {31'h0, s_we}, 32'd0);
            chk("rst_mem_addr", s_addr, 32'h0);
            chk("rst_mem_wdata", s_wdata, 32'h0);
            chk("rst_mem_whb", {29'h0, s_whb}, 32'd0);
            chk("rst_req_ready", {31'h0, s_ready}, 32'd1);
        end
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_check(tbl[i].w, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                      tbl[i].lat, tbl[i].err, tbl[i].rd, tbl[i].wec, tbl[i].whb, tbl[i].addr1);
        end

        // Reset during the HI half of a split store.
        sel = 1;
        @(negedge clk);
        chk("ready_idle", {31'h0, s_ready}, 32'd1);
        set_req(1'b1, 1'b1, 3'd2, 32'h0000_0041, 32'h5566_7788);
        @(negedge clk);
        set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("lo_addr", s_addr, 32'h0000_0041);
        chk("lo_wdata", s_wdata, 32'h0000_7788);
        @(negedge clk);
        chk("hi_addr", s_addr, 32'h0000_0043);
        chk("hi_wdata", s_wdata, 32'h0000_5566);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nrv = 0;
        for (int k = 0; k < 3; k++) begin
            if (s_rv) nrv++;
            @(negedge clk);
        end
        chk("no_rsp_after_rst", 32'(nrv), 32'd0);
        ref_mem1 = put(ref_mem1, 32'h0000_0041, 2, 32'h0000_7788);
        chk_img(1);
        run_check(1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 2, 1'b0, 32'h0077_8800, 0, 3'd2, 32'h0);

        // Randomized requests against the request-level model.
        for (int i = 0; i < 210; i++) begin
            w  = (i < 150) ? 1 : 0;
            we = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 7) == 0) a = {24'hFF_FFFF, 8'($urandom)};
            else                           a = 32'($urandom_range(0, 255));
            d  = $urandom;
            mis   = (f3 == 3'd2) && (a[1:0] != 2'd0);
            split = mis && (w == 1);
            if (!ref_legal(we, f3) || (mis && w == 0)) begin
                e_lat = 1; e_err = 1'b1; e_rd = 32'h0; e_wec = 0;
            end else begin
                e_lat = split ? 3 : 2;
                e_err = 1'b0;
                e_rd  = we ? 32'h0 : ref_load((w == 1) ? ref_mem1 : ref_mem0, a, f3);
                e_wec = we ? (split ? 2 : 1) : 0;
            end
            run_check(w, we, f3, a, d, e_lat, e_err, e_rd, e_wec,
                      ref_whb(we, f3, split), a + 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
